// File: rtl/fetch_pc_reg_pkg.sv
// Shared CPU definitions for the fetch stage: PC constants, exception codes,
// PC-select codes, the F/D payload struct and the fetch-address check.
package fetch_pc_reg_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_EXC   = 32'h0000_4180;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [3:0] {
    PCSEL_NORMAL = 4'd0,
    PCSEL_BRANCH = 4'd1,
    PCSEL_JUMP   = 4'd2,
    PCSEL_JR     = 4'd3
  } pcsel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } fd_t;

  // Fetch address error: misaligned or outside the instruction memory window.
  function automatic logic adel_check(input logic [31:0] pc);
    logic bad;
    bad = 1'b0;
    if (pc[1:0] != 2'b00) begin
      bad = 1'b1;
    end else if (pc < IM_LO) begin
      bad = 1'b1;
    end else if (pc > IM_HI) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

endpackage

// File: rtl/fetch_pc_reg_fd_reg.sv
// F/D pipeline register: clears on reset or redirect, holds on stall,
// otherwise captures the fetched instruction (squashed on address error).
module fd_reg
  import fetch_pc_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  input  logic        f_adel,
  input  logic        f_bd,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exccode,
  output logic        d_bd
);

  fd_t fd_r;
  fd_t load_s;

  // Build the payload loaded on a normal advance.
  always_comb begin
    load_s.pc = f_pc;
    load_s.bd = f_bd;
    if (f_adel) begin
      load_s.instr = 32'd0;
      load_s.exc   = EXC_ADEL;
    end else begin
      load_s.instr = f_instr;
      load_s.exc   = EXC_NONE;
    end
  end

  // Pipeline register with reset > redirect > stall > advance priority.
  always_ff @(posedge clk) begin
    if (reset || req) begin
      fd_r <= '0;
    end else if (stall) begin
      fd_r <= fd_r;
    end else begin
      fd_r <= load_s;
    end
  end

  assign d_pc      = fd_r.pc;
  assign d_instr   = fd_r.instr;
  assign d_exccode = fd_r.exc;
  assign d_bd      = fd_r.bd;

endmodule

// File: rtl/fetch_pc_reg.sv
// Fetch stage: program counter register, fetch address-error and delay-slot
// flags, and the F/D pipeline register.
module fetch_pc_reg
  import fetch_pc_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_NPC,
  input  logic [3:0]  D_PCsel,
  input  logic        stall,
  input  logic        Req,
  input  logic [31:0] F_Instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD
);

  logic [31:0] pc_r;
  logic        f_adel_s;
  logic        f_bd_s;

  // PC register: reset > redirect > stall > next-PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= PC_RESET;
    end else if (Req) begin
      pc_r <= PC_EXC;
    end else if (stall) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= F_NPC;
    end
  end

  assign F_PC = pc_r;

  // The instruction being fetched is a delay slot whenever D redirects control.
  always_comb begin
    f_adel_s = adel_check(pc_r);
    f_bd_s   = (D_PCsel != PCSEL_NORMAL);
  end

  fd_reg u_fd_reg (
    .clk       (clk),
    .reset     (reset),
    .req       (Req),
    .stall     (stall),
    .f_pc      (pc_r),
    .f_instr   (F_Instr),
    .f_adel    (f_adel_s),
    .f_bd      (f_bd_s),
    .d_pc      (D_PC),
    .d_instr   (D_Instr),
    .d_exccode (D_ExcCode),
    .d_bd      (D_BD)
  );

endmodule

// File: tb/tb_fetch_pc_reg.sv
// Directed bench for fetch_pc_reg; the IM model returns 0xA500_0000 ^ PC[15:0].
module tb_fetch_pc_reg;

  logic        clk;
  logic        reset;
  logic [31:0] F_NPC;
  logic [3:0]  D_PCsel;
  logic        stall;
  logic        Req;
  logic [31:0] F_Instr;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [4:0]  D_ExcCode;
  logic        D_BD;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_pc_reg dut (
    .clk       (clk),
    .reset     (reset),
    .F_NPC     (F_NPC),
    .D_PCsel   (D_PCsel),
    .stall     (stall),
    .Req       (Req),
    .F_Instr   (F_Instr),
    .F_PC      (F_PC),
    .D_PC      (D_PC),
    .D_Instr   (D_Instr),
    .D_ExcCode (D_ExcCode),
    .D_BD      (D_BD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign F_Instr = 32'hA500_0000 ^ {16'd0, F_PC[15:0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] exc, input logic [31:0] bd);
    chk({tag, ".D_PC"}, D_PC, pc);
    chk({tag, ".D_Instr"}, D_Instr, instr);
    chk({tag, ".D_ExcCode"}, {27'd0, D_ExcCode}, exc);
    chk({tag, ".D_BD"}, {31'd0, D_BD}, bd);
  endtask

  initial begin
    reset = 1'b1; F_NPC = 32'h0000_1234; D_PCsel = 4'd0; stall = 1'b0; Req = 1'b0;
    tick();
    chk("rst1.F_PC", F_PC, 32'h0000_3000);
    chk_d("rst1", 32'h0, 32'h0, 32'h0, 32'h0);
    Req = 1'b1; stall = 1'b1; D_PCsel = 4'd1;
    tick();
    chk("rst2.F_PC", F_PC, 32'h0000_3000);
    chk_d("rst2", 32'h0, 32'h0, 32'h0, 32'h0);

    // sequential fetch
    reset = 1'b0; Req = 1'b0; stall = 1'b0; D_PCsel = 4'd0;
    F_NPC = 32'h0000_3004; tick();
    chk("seq1.F_PC", F_PC, 32'h0000_3004);
    chk_d("seq1", 32'h0000_3000, 32'hA500_3000, 32'd0, 32'd0);
    F_NPC = 32'h0000_3008; tick();
    chk("seq2.F_PC", F_PC, 32'h0000_3008);
    chk_d("seq2", 32'h0000_3004, 32'hA500_3004, 32'd0, 32'd0);
    F_NPC = 32'h0000_300C; tick();
    chk("seq3.F_PC", F_PC, 32'h0000_300C);
    chk_d("seq3", 32'h0000_3008, 32'hA500_3008, 32'd0, 32'd0);
    F_NPC = 32'h0000_3010; tick();
    chk("seq4.F_PC", F_PC, 32'h0000_3010);
    chk_d("seq4", 32'h0000_300C, 32'hA500_300C, 32'd0, 32'd0);

    // two-cycle stall
    stall = 1'b1; F_NPC = 32'h0000_3014; tick();
    chk("stl1.F_PC", F_PC, 32'h0000_3010);
    chk_d("stl1", 32'h0000_300C, 32'hA500_300C, 32'd0, 32'd0);
    tick();
    chk("stl2.F_PC", F_PC, 32'h0000_3010);
    chk_d("stl2", 32'h0000_300C, 32'hA500_300C, 32'd0, 32'd0);
    stall = 1'b0; tick();
    chk("stl3.F_PC", F_PC, 32'h0000_3014);
    chk_d("stl3", 32'h0000_3010, 32'hA500_3010, 32'd0, 32'd0);

    // branch delay slot
    D_PCsel = 4'd1; F_NPC = 32'h0000_3018; tick();
    chk("bd1.F_PC", F_PC, 32'h0000_3018);
    chk_d("bd1", 32'h0000_3014, 32'hA500_3014, 32'd0, 32'd1);
    D_PCsel = 4'd0; F_NPC = 32'h0000_301C; tick();
    chk_d("bd2", 32'h0000_3018, 32'hA500_3018, 32'd0, 32'd0);

    // address errors and window boundaries
    F_NPC = 32'h0000_3002; tick();
    chk("mis1.F_PC", F_PC, 32'h0000_3002);
    F_NPC = 32'h0000_3020; tick();
    chk_d("mis2", 32'h0000_3002, 32'h0, 32'd4, 32'd0);
    F_NPC = 32'h0000_7000; tick();
    chk_d("hi1", 32'h0000_3020, 32'hA500_3020, 32'd0, 32'd0);
    F_NPC = 32'h0000_3024; tick();
    chk_d("hi2", 32'h0000_7000, 32'h0, 32'd4, 32'd0);
    F_NPC = 32'h0000_6FFC; tick();
    F_NPC = 32'h0000_2FFC; tick();
    chk_d("top", 32'h0000_6FFC, 32'hA500_6FFC, 32'd0, 32'd0);
    F_NPC = 32'h0000_3020; tick();
    chk_d("lo", 32'h0000_2FFC, 32'h0, 32'd4, 32'd0);
    chk("lo.F_PC", F_PC, 32'h0000_3020);

    // reset during stall
    stall = 1'b1; F_NPC = 32'h0000_5555; tick();
    chk("rstl1.F_PC", F_PC, 32'h0000_3020);
    reset = 1'b1; tick();
    chk("rstl2.F_PC", F_PC, 32'h0000_3000);
    chk_d("rstl2", 32'h0, 32'h0, 32'd0, 32'd0);
    reset = 1'b0; stall = 1'b0; F_NPC = 32'h0000_3004; tick();
    chk("rstl3.F_PC", F_PC, 32'h0000_3004);
    chk_d("rstl3", 32'h0000_3000, 32'hA500_3000, 32'd0, 32'd0);

    // Req with stall
    Req = 1'b1; stall = 1'b1; D_PCsel = 4'd2; F_NPC = 32'h0000_3008; tick();
    chk("req1.F_PC", F_PC, 32'h0000_4180);
    chk_d("req1", 32'h0, 32'h0, 32'd0, 32'd0);
    Req = 1'b0; stall = 1'b0; D_PCsel = 4'd0; F_NPC = 32'h0000_4184; tick();
    chk("req2.F_PC", F_PC, 32'h0000_4184);
    chk_d("req2", 32'h0000_4180, 32'hA500_4180, 32'd0, 32'd0);

    // wrap-around
    F_NPC = 32'hFFFF_FFFC; tick();
    chk("wrap1.F_PC", F_PC, 32'hFFFF_FFFC);
    F_NPC = 32'h0000_0000; tick();
    chk("wrap2.F_PC", F_PC, 32'h0000_0000);
    chk_d("wrap2", 32'hFFFF_FFFC, 32'h0, 32'd4, 32'd0);
    F_NPC = 32'h0000_3000; tick();
    chk_d("wrap3", 32'h0000_0000, 32'h0, 32'd4, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_reg.md
FETCH_PC_REG -- requirements
Module: fetch_pc_reg

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 F_NPC  input  32  next-PC from the next-PC block.
REQ-004 D_PCsel  input  4  D-stage PC-select code: 0 normal, 1 branch, 2 jump, 3 jump-register.
REQ-005 stall  input  1  hazard stall, active-high: freezes the PC register and the F/D register.
REQ-006 Req  input  1  exception/interrupt redirect request, active-high.
REQ-007 F_Instr  input  32  instruction word read combinationally from IM at F_PC.
REQ-008 F_PC  output  32  current fetch address, also driven to the IM address.
REQ-009 D_PC  output  32  PC of the instruction held in D.
REQ-010 D_Instr  output  32  instruction held in D.
REQ-011 D_ExcCode  output  5  exception code carried into D: 0 none, 4 AdEL.
REQ-012 D_BD  output  1  D instruction sits in a branch delay slot.

Function
REQ-013 F_PC SHALL be a 32-bit register with next value chosen by priority: reset, then Req, then stall, then normal.
- reset: 0x0000_3000.
- Req: 0x0000_4180.
- stall: hold.
- normal: F_NPC.
REQ-014 F_AdEL SHALL be computed combinationally as true when any of these holds:
- F_PC[1:0] != 0;
- F_PC < 0x0000_3000;
- F_PC > 0x0000_6FFC.
REQ-015 F_BD SHALL equal (D_PCsel != 0), computed combinationally.
REQ-016 The F/D register SHALL update each cycle by priority: reset, then Req, then stall, then normal.
- reset or Req: clear. D_PC = 0x0000_0000, D_Instr = 0, D_ExcCode = 0, D_BD = 0.
- stall: hold all fields.
- normal load:
  - D_PC = F_PC.
  - D_Instr = F_AdEL ? 0 : F_Instr.
  - D_ExcCode = F_AdEL ? 4 : 0.
  - D_BD = F_BD.
REQ-017 Req and stall asserted together SHALL behave as Req only; stall is ignored.
REQ-018 F-to-D latency SHALL be exactly one cycle when neither stall nor Req is asserted.
REQ-019 A stall lasting N cycles SHALL hold F_PC and all D outputs for exactly N edges, with no fetch lost or duplicated.
REQ-020 F_PC arithmetic SHALL be modulo 2^32; a wrapped F_NPC SHALL be loaded unmodified and flagged via REQ-014.
REQ-021 A misaligned address SHALL never reach D_Instr as a non-zero word.
REQ-022 The block SHALL have no combinational path from any input to D_* outputs.
REQ-023 F_PC SHALL depend only on registered state; F_NPC feeds back into F_PC only through the register.

Reset
REQ-024 Reset SHALL be synchronous, active-high, and take effect on the first rising edge while asserted.
REQ-025 While reset is held: F_PC = 0x0000_3000 and all D outputs are zero.
REQ-026 Reset SHALL override Req and stall.
REQ-027 Reset asserted mid-stall or mid-Req SHALL discard the held state with no residue after release.

Structure
REQ-028 The following SHALL live in the shared CPU definitions package:
- PC_RESET = 0x0000_3000
- PC_EXC = 0x0000_4180
- IM_LO = 0x0000_3000
- IM_HI = 0x0000_6FFC
- EXC_NONE = 0
- EXC_ADEL = 4
- the PCsel code values
REQ-029 The block SHALL contain one natural sub-module, fd_reg (the F/D pipeline register), instantiated once.
REQ-030 The PC register and AdEL/BD logic SHALL stay in the top module.

Verification
REQ-031 Reset, then F_NPC = F_PC + 4 for 3 cycles:
- F_PC goes 3000, 3004, 3008, 300C.
- D_PC lags F_PC by one cycle.
- D_Instr equals the IM words in order.
REQ-032 stall high for 2 cycles while F_PC = 3010:
- F_PC stays 3010 for both cycles.
- D_PC stays 300C for both cycles.
- After release, F_PC = F_NPC and D_PC = 3010.
REQ-033 D_PCsel = 1 for one cycle while F_PC = 3014:
- next cycle D_PC = 3014 and D_BD = 1.
- the following cycle D_BD = 0.
REQ-034 F_NPC = 0x0000_3002 loaded:
- next cycle D_PC = 3002, D_Instr = 0, D_ExcCode = 4.
- Repeat with F_NPC = 0x0000_7000: same response.
REQ-035 Req and stall asserted in the same cycle:
- next F_PC = 4180.
- D_PC = 0, D_Instr = 0, D_ExcCode = 0, D_BD = 0.
REQ-036 reset asserted during a stall with F_PC = 3020:
- next F_PC = 3000 and all D outputs = 0.
- After release, the fetch sequence resumes at 3000.
